// File: rtl/simmem_pkg.sv
// Shared types and helpers for the simmem delay calculator.
// Used by simmem_delay_calculator (optional statistics via SIMMEM_DELAY_CALC_STATS_EN).
package simmem_pkg;

    localparam int unsigned DefIdWidth    = 4;
    localparam int unsigned DefDelayWidth = 16;

    typedef enum logic {
        ROW_CLOSED = 1'b0,
        ROW_OPEN   = 1'b1
    } row_state_e;

    typedef struct packed {
        logic [DefIdWidth-1:0]    id;
        logic [DefDelayWidth-1:0] delay;
    } delay_entry_t;

    // Add two unsigned values, clamping the result to max_val.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [63:0] max_val);
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[63:0];
    endfunction

endpackage

// File: rtl/simmem_delay_calculator.sv
// Per-request DRAM bank delay model: row hit/miss cost, burst cost and queuing.
// Define SIMMEM_DELAY_CALC_STATS_EN to add row_hits_o / row_misses_o counters.
module simmem_delay_calculator
    import simmem_pkg::*;
#(
    parameter int unsigned IdWidth         = 4,
    parameter int unsigned AddrWidth       = 32,
    parameter int unsigned LenWidth        = 8,
    parameter int unsigned DelayWidth      = 16,
    parameter int unsigned RowAddrLsb      = 10,
    parameter int unsigned RowHitCost      = 10,
    parameter int unsigned RowMissCost     = 30,
    parameter int unsigned BeatCost        = 2,
    parameter int unsigned IdleCloseCycles = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [IdWidth-1:0]    req_id_i,
    input  logic [AddrWidth-1:0]  req_addr_i,
    input  logic [LenWidth-1:0]   req_len_i,
    output logic                  delay_valid_o,
    input  logic                  delay_ready_i,
    output logic [IdWidth-1:0]    delay_id_o,
    output logic [DelayWidth-1:0] delay_o
`ifdef SIMMEM_DELAY_CALC_STATS_EN
    ,
    output logic [31:0]           row_hits_o,
    output logic [31:0]           row_misses_o
`endif
);

    localparam int unsigned SvcWidth  = DelayWidth + LenWidth + 2;
    localparam int unsigned RowWidth  = AddrWidth - RowAddrLsb;
    localparam int unsigned IdleWidth = $clog2(IdleCloseCycles) + 1;
    localparam logic [DelayWidth-1:0] DelayMax = '1;

    row_state_e            state_q, state_d;
    logic [RowWidth-1:0]   open_row_q, open_row_d;
    logic [IdleWidth-1:0]  idle_cnt_q, idle_cnt_d;
    logic [DelayWidth-1:0] busy_q, busy_d;
    logic [DelayWidth-1:0] base;
    logic [DelayWidth-1:0] new_delay;
    logic [SvcWidth-1:0]   row_cost;
    logic [SvcWidth-1:0]   beats;
    logic [SvcWidth-1:0]   service;
    logic [RowWidth-1:0]   req_row;
    logic                  accept;
    logic                  idle;
    logic                  hit;

    assign req_ready_o = !delay_valid_o || delay_ready_i;
    assign accept      = req_valid_i && req_ready_o;
    assign req_row     = req_addr_i[AddrWidth-1:RowAddrLsb];
    assign idle        = !accept && (busy_q == '0);

    // Time the bank still needs for earlier work, one cycle having passed.
    assign base      = (busy_q == '0) ? '0 : busy_q - 1'b1;
    assign row_cost  = hit ? SvcWidth'(RowHitCost) : SvcWidth'(RowMissCost);
    assign beats     = SvcWidth'(req_len_i) + SvcWidth'(1);
    assign service   = row_cost + beats * SvcWidth'(BeatCost);
    assign new_delay = DelayWidth'(sat_add(64'(base), 64'(service), 64'(DelayMax)));
    assign busy_d    = accept ? new_delay : base;

    // Row FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ROW_CLOSED;
            open_row_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            open_row_q <= open_row_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    // Row FSM: next state; the row closes on the IdleCloseCycles-th consecutive idle cycle
    always_comb begin
        state_d    = state_q;
        open_row_d = open_row_q;
        idle_cnt_d = idle_cnt_q;
        if (accept) begin
            state_d    = ROW_OPEN;
            open_row_d = req_row;
            idle_cnt_d = '0;
        end else if (idle) begin
            if (idle_cnt_q == IdleWidth'(IdleCloseCycles - 1)) begin
                state_d    = ROW_CLOSED;
                idle_cnt_d = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end else begin
            idle_cnt_d = '0;
        end
    end

    // Row FSM: outputs
    always_comb begin
        hit = (state_q == ROW_OPEN) && (req_row == open_row_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Output register: a stalled entry keeps counting down so the bank sees the remaining delay.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            delay_valid_o <= 1'b0;
            delay_id_o    <= '0;
            delay_o       <= '0;
        end else if (accept) begin
            delay_valid_o <= 1'b1;
            delay_id_o    <= req_id_i;
            delay_o       <= new_delay;
        end else if (delay_valid_o && !delay_ready_i) begin
            delay_o <= (delay_o == '0) ? '0 : delay_o - 1'b1;
        end else if (delay_valid_o) begin
            delay_valid_o <= 1'b0;
        end
    end

`ifdef SIMMEM_DELAY_CALC_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_hits_o   <= '0;
            row_misses_o <= '0;
        end else if (accept) begin
            if (hit) begin
                row_hits_o <= row_hits_o + 32'd1;
            end else begin
                row_misses_o <= row_misses_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_simmem_delay_calculator.sv
// Bench for simmem_delay_calculator: integer-level bank model checked every cycle,
// directed vectors with literal expectations, plus an 8-bit-delay instance for saturation.
module tb_simmem_delay_calculator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, delay_valid, delay_ready;
    logic [3:0]  req_id, delay_id;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [15:0] delay;

    logic        v8, rdy8, dv8, dr8;
    logic [3:0]  id8, did8;
    logic [31:0] a8;
    logic [7:0]  l8, d8;

`ifdef SIMMEM_DELAY_CALC_STATS_EN
    logic [31:0] hits, misses, hits8, misses8;
`endif

    always #5 clk = ~clk;

    simmem_delay_calculator dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_id_i(req_id), .req_addr_i(req_addr), .req_len_i(req_len),
        .delay_valid_o(delay_valid), .delay_ready_i(delay_ready),
        .delay_id_o(delay_id), .delay_o(delay)
`ifdef SIMMEM_DELAY_CALC_STATS_EN
        , .row_hits_o(hits), .row_misses_o(misses)
`endif
    );

    simmem_delay_calculator #(.DelayWidth(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(v8), .req_ready_o(rdy8),
        .req_id_i(id8), .req_addr_i(a8), .req_len_i(l8),
        .delay_valid_o(dv8), .delay_ready_i(dr8),
        .delay_id_o(did8), .delay_o(d8)
`ifdef SIMMEM_DELAY_CALC_STATS_EN
        , .row_hits_o(hits8), .row_misses_o(misses8)
`endif
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Bank model in plain integers: remaining busy time, open row, idle streak, output entry.
    int m_busy = 0, m_idle = 0, m_delay = 0, m_id = 0, m_row = 0;
    bit m_valid = 0, m_open = 0;
    int t_base, t_svc;
    bit t_acc, t_idle, t_hit;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_idle = 0; m_delay = 0; m_id = 0; m_row = 0;
            m_valid = 0; m_open = 0;
        end else begin
            t_acc  = req_valid && (!m_valid || delay_ready);
            t_base = (m_busy > 0) ? m_busy - 1 : 0;
            t_idle = !t_acc && (m_busy == 0);
            if (t_acc) begin
                t_hit   = m_open && (m_row == int'(req_addr >> 10));
                t_svc   = (t_hit ? 10 : 30) + (int'(req_len) + 1) * 2;
                m_busy  = (t_base + t_svc > 65535) ? 65535 : t_base + t_svc;
                m_valid = 1; m_id = int'(req_id); m_delay = m_busy;
                m_open  = 1; m_row = int'(req_addr >> 10); m_idle = 0;
            end else begin
                m_busy = t_base;
                if (m_valid && !delay_ready) m_delay = (m_delay > 0) ? m_delay - 1 : 0;
                else if (m_valid) m_valid = 0;
                if (t_idle) begin
                    if (m_idle == 15) begin m_open = 0; m_idle = 0; end
                    else m_idle++;
                end else begin
                    m_idle = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_valid", delay_valid, m_valid);
        chk("model_ready", req_ready, (!m_valid || delay_ready));
        chk("model_id", delay_id, m_id);
        chk("model_delay", delay, m_delay);
    end

    task automatic drive(input bit v, input int id, input int addr, input int len, input bit dr);
        req_valid   = v;
        req_id      = id[3:0];
        req_addr    = addr;
        req_len     = len[7:0];
        delay_ready = dr;
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 1);
    endtask

    int addr_tab[12] = '{'h400, 'h7FC, 'h800, 'h800, 'h0, 'hC00, 'hC10, 'h400, 'h12345, 'h12000, 'h400, 'h404};
    int len_tab[12]  = '{0, 3, 7, 255, 1, 0, 15, 2, 4, 63, 0, 128};

    initial begin
        rst_n = 1'b0;
        req_valid = 0; req_id = 0; req_addr = 0; req_len = 0; delay_ready = 0;
        v8 = 0; id8 = 0; a8 = 0; l8 = 0; dr8 = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("reset_valid", delay_valid, 0);
        chk("reset_ready", req_ready, 1);
        chk("reset_delay", delay, 0);

        // First request, row closed: 30 + 2
        drive(1, 3, 'h400, 0, 1);
        chk("first_valid", delay_valid, 1);
        chk("first_id", delay_id, 3);
        chk("first_delay", delay, 32);
        // Same row, queued behind 31 remaining cycles: 31 + 10 + 8
        drive(1, 5, 'h7FC, 3, 1);
        chk("hit_id", delay_id, 5);
        chk("hit_delay", delay, 49);

        idle_cycles(80);
        drive(1, 6, 'h400, 0, 1);
        chk("closed_miss_delay", delay, 32);
        // 15 idle cycles after draining: row still open
        idle_cycles(47);
        drive(1, 1, 'h400, 0, 1);
        chk("idle15_hit_delay", delay, 12);
        // 16 idle cycles after draining: row closed
        idle_cycles(28);
        drive(1, 2, 'h400, 0, 1);
        chk("idle16_miss_delay", delay, 32);

        // Reset while an entry is stalled
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midreset_valid", delay_valid, 0);
        chk("midreset_delay", delay, 0);
        chk("midreset_ready", req_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;

        // Stall: remaining delay counts down, id held, ready low
        drive(1, 3, 'h400, 0, 0);
        chk("stall_start_delay", delay, 32);
        chk("stall_start_ready", req_ready, 0);
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 0, 0, 0);
            chk("stall_delay", delay, 32 - k);
            chk("stall_id", delay_id, 3);
            chk("stall_ready", req_ready, 0);
        end
        // Consume and accept in the same cycle: 26 + 30 + 4
        drive(1, 7, 'h800, 1, 1);
        chk("noBubble_valid", delay_valid, 1);
        chk("noBubble_id", delay_id, 7);
        chk("noBubble_delay", delay, 60);

        // Mixed traffic with intermittent back-pressure, checked by the model
        for (int i = 0; i < 12; i++) begin
            drive((i % 3) != 2, i, addr_tab[i], len_tab[i], (i % 4) != 1);
            drive(0, 0, 0, 0, (i % 2) == 0);
        end
        idle_cycles(10);

        // 8-bit delay: saturates and never wraps
        v8 = 1; id8 = 1; a8 = 0; l8 = 255; dr8 = 1;
        @(posedge clk); #1;
        chk("sat8_first", d8, 255);
        id8 = 2; l8 = 0;
        @(posedge clk); #1;
        chk("sat8_second", d8, 255);
        chk("sat8_id", did8, 2);
        v8 = 0;
        @(posedge clk); #1;
        chk("sat8_consumed", dv8, 0);
        v8 = 1; id8 = 4;
        @(posedge clk); #1;
        chk("sat8_third", d8, 255);
        v8 = 0;
        idle_cycles(3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
